// File: rtl/spi_transmit.sv
// SPI slave transmitter: serialises words from a one-entry holding buffer onto sdo, framed by ncs.
// Define SPI_TX_LSB_FIRST_EN for LSB-first bit order; the default build sends MSB first.
module spi_transmit #(
    parameter int                     messageBits = 8,
    parameter logic [messageBits-1:0] fillWord    = '0
) (
    input  logic                   spiClk,
    input  logic                   reset,
    input  logic                   ncs,
    output logic                   sdo,
    input  logic [messageBits-1:0] txData,
    input  logic                   txValid,
    output logic                   txReady,
    output logic                   frameDone,
    output logic                   underrun
);

    localparam int CW = (messageBits > 1) ? $clog2(messageBits) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(messageBits - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                 state, stateNext;
    logic [messageBits-1:0] hold, holdNext;
    logic                   holdValid, holdValidNext;
    logic [messageBits-1:0] shiftReg, shiftNext;
    logic [CW-1:0]          bitCounter, bitCounterNext;
    logic                   sdoNext;
    logic                   frameDoneNext;
    logic                   underrunNext;
    logic                   load;
    logic [messageBits-1:0] loadWord;

    // Ready comes straight from the buffer flag so the upstream valid never loops back combinationally.
    assign txReady = ~holdValid;

    always_ff @(posedge spiClk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            // NOTE: the hold data is reset too, so an underrun never exposes stale or X contents.
            hold       <= '0;
            holdValid  <= 1'b0;
            shiftReg   <= '0;
            bitCounter <= LAST_BIT;
            sdo        <= 1'b0;
            frameDone  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
            state      <= stateNext;
            hold       <= holdNext;
            holdValid  <= holdValidNext;
            shiftReg   <= shiftNext;
            bitCounter <= bitCounterNext;
            sdo        <= sdoNext;
            frameDone  <= frameDoneNext;
            underrun   <= underrunNext;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stateNext      = state;
        holdNext       = hold;
        holdValidNext  = holdValid;
        shiftNext      = shiftReg;
        bitCounterNext = bitCounter;
        sdoNext        = sdo;
        frameDoneNext  = 1'b0;
        underrunNext   = underrun;
        load           = 1'b0;
        loadWord       = holdValid ? hold : fillWord;

        if (txValid && !holdValid) begin
            holdNext      = txData;
            holdValidNext = 1'b1;
        end

        case (state)
            IDLE: begin
                sdoNext = 1'b0;
                if (!ncs) begin
                    load      = 1'b1;
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (bitCounter != '0) begin
                    if (!ncs) begin
`ifdef SPI_TX_LSB_FIRST_EN
                        shiftNext = shiftReg >> 1;
                        sdoNext   = shiftReg[1];
`else
                        shiftNext = shiftReg << 1;
                        sdoNext   = shiftReg[messageBits-2];
`endif
                        bitCounterNext = bitCounter - CW'(1);
                    end else begin
                        // Deselected mid-word: the partial word is dropped, the buffer is left alone.
                        stateNext = IDLE;
                        sdoNext   = 1'b0;
                    end
                end else begin
                    // Last bit was sampled on the previous falling edge, so the word counts even if ncs rose.
                    frameDoneNext = 1'b1;
                    if (!ncs) begin
                        load = 1'b1;
                    end else begin
                        stateNext = IDLE;
                        sdoNext   = 1'b0;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase

        // A word accepted at this same edge lands in hold but is not seen by this load.
        if (load) begin
            shiftNext      = loadWord;
            bitCounterNext = LAST_BIT;
            if (holdValid) begin
                holdValidNext = 1'b0;
            end else begin
                underrunNext = 1'b1;
            end
`ifdef SPI_TX_LSB_FIRST_EN
            sdoNext = loadWord[0];
`else
            sdoNext = loadWord[messageBits-1];
`endif
        end
    end

endmodule

// File: tb/tb_spi_transmit.sv
// Testbench for spi_transmit: the bench plays the MCU, a word-level model predicts each frame,
// and a falling-edge monitor rebuilds words from sdo and checks them against the scoreboard.
module tb_spi_transmit;

    localparam int         MB   = 8;
    localparam logic [7:0] FILL = 8'h00;

    logic          spiClk = 1'b0;
    logic          reset;
    logic          ncs;
    logic          sdo;
    logic [MB-1:0] txData;
    logic          txValid;
    logic          txReady;
    logic          frameDone;
    logic          underrun;

    spi_transmit #(
        .messageBits(MB),
        .fillWord   (FILL)
    ) dut (
        .spiClk   (spiClk),
        .reset    (reset),
        .ncs      (ncs),
        .sdo      (sdo),
        .txData   (txData),
        .txValid  (txValid),
        .txReady  (txReady),
        .frameDone(frameDone),
        .underrun (underrun)
    );

    always #5 spiClk = ~spiClk;

    // Reference model state, owned by the driver
    logic [MB-1:0] hold_q[$];
    logic [MB-1:0] exp_q[$];
    logic [MB-1:0] cur_word = '0;
    int            pos = 0;
    logic          underrun_m = 1'b0;
    logic          pend_v = 1'b0;
    logic [MB-1:0] pend_d = '0;
    logic          stim_done = 1'b0;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic queue_word(input logic [MB-1:0] d);
        pend_v = 1'b1;
        pend_d = d;
    endtask

    // One SPI clock: drive inputs, let the edge happen, advance the model, return at the falling edge.
    task automatic clk_cycle(input logic n);
        logic was_empty;
        ncs     = n;
        txValid = pend_v;
        txData  = pend_v ? pend_d : MB'($urandom);
        @(posedge spiClk);
        was_empty = (hold_q.size() == 0);
        if (!n) begin
            if (pos == 0) begin
                if (hold_q.size() != 0) begin
                    cur_word = hold_q.pop_front();
                end else begin
                    cur_word   = FILL;
                    underrun_m = 1'b1;
                end
            end
            pos = (pos + 1) % MB;
            if (pos == 0) exp_q.push_back(cur_word);
        end else begin
            pos = 0;
        end
        if (pend_v && was_empty) begin
            hold_q.push_back(pend_d);
            pend_v = 1'b0;
        end
        @(negedge spiClk);
    endtask

    task automatic frame(input int nbits);
        for (int j = 0; j < nbits; j++) clk_cycle(1'b0);
        clk_cycle(1'b1);
    endtask

    // Monitor: collects bits launched by edges with ncs low, checks each completed word and status flags.
    logic last_ncs_low = 1'b0;
    logic bits[$];

    always @(posedge spiClk) last_ncs_low <= !ncs && !reset;

    always @(negedge spiClk) begin
        logic [MB-1:0] w;
        if (reset) begin
            bits.delete();
            check("reset_sdo", 32'(sdo), 32'(0));
            check("reset_txReady", 32'(txReady), 32'(1));
            check("reset_frameDone", 32'(frameDone), 32'(0));
            check("reset_underrun", 32'(underrun), 32'(0));
        end else begin
            if (frameDone) begin
                if (exp_q.size() == 0) begin
                    check("spurious_frameDone", 32'(frameDone), 32'(0));
                end else begin
                    check("frame_bits", 32'(bits.size()), 32'(MB));
                    w = '0;
                    for (int i = 0; i < MB && i < bits.size(); i++) begin
`ifdef SPI_TX_LSB_FIRST_EN
                        w[i] = bits[i];
`else
                        w[MB-1-i] = bits[i];
`endif
                    end
                    check("frame_word", 32'(w), 32'(exp_q.pop_front()));
                end
                bits.delete();
            end
            if (last_ncs_low) begin
                bits.push_back(sdo);
            end else begin
                check("idle_sdo", 32'(sdo), 32'(0));
                bits.delete();
            end
            check("txReady", 32'(txReady), 32'(hold_q.size() == 0));
            check("underrun", 32'(underrun), 32'(underrun_m));
            if (stim_done) begin
                check("words_outstanding", 32'(exp_q.size()), 32'(0));
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        ncs     = 1'b1;
        txValid = 1'b0;
        txData  = '0;
        repeat (2) @(negedge spiClk);
        #1 reset = 1'b0;

        // Single word, then deselect on the completion edge
        queue_word(8'hA5);
        clk_cycle(1'b1);
        frame(8);

        // Second word queued while the first shifts; streams with no gap
        queue_word(8'h3C);
        clk_cycle(1'b1);
        queue_word(8'hC3);
        frame(16);

        // Underrun: nothing queued, fill word goes out and the flag sticks
        frame(8);
        queue_word(8'h96);
        clk_cycle(1'b1);
        frame(8);

        // Abort after three bits, then a clean frame
        queue_word(8'hFF);
        clk_cycle(1'b1);
        frame(3);
        queue_word(8'h81);
        clk_cycle(1'b1);
        frame(8);

        // Buffer full: the second word waits until the load frees the buffer
        queue_word(8'h11);
        clk_cycle(1'b1);
        queue_word(8'h22);
        clk_cycle(1'b1);
        frame(16);

        // Asynchronous reset mid-word, asserted between clock edges
        queue_word(8'h5A);
        clk_cycle(1'b1);
        for (int j = 0; j < 4; j++) clk_cycle(1'b0);
        @(posedge spiClk);
        #2;
        reset   = 1'b1;
        ncs     = 1'b1;
        txValid = 1'b0;
        hold_q.delete();
        pend_v     = 1'b0;
        underrun_m = 1'b0;
        pos        = 0;
        @(negedge spiClk);
        @(negedge spiClk);
        #1 reset = 1'b0;

        queue_word(8'h01);
        clk_cycle(1'b1);
        frame(8);

        // Randomised traffic: streaming runs, gaps, aborts, writes arriving mid-frame
        for (int it = 0; it < 40; it++) begin
            int nwords;
            int nbits;
            if (!pend_v && $urandom_range(0, 3) != 0) queue_word(MB'($urandom));
            repeat ($urandom_range(0, 2)) clk_cycle(1'b1);
            nwords = $urandom_range(1, 3);
            if ($urandom_range(0, 4) == 0) nbits = (nwords - 1) * MB + $urandom_range(1, MB - 1);
            else nbits = nwords * MB;
            for (int j = 0; j < nbits; j++) begin
                if (!pend_v && $urandom_range(0, 5) == 0) queue_word(MB'($urandom));
                clk_cycle(1'b0);
            end
            clk_cycle(1'b1);
        end

        repeat (3) clk_cycle(1'b1);
        stim_done = 1'b1;
    end

endmodule
